// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - I2C target bus pins and user byte interface
// Groups the open-drain bus lines with the receive/transmit byte handshakes.
interface i2c_slave_if;
  logic       i2c_scl_in;
  logic       i2c_sda_in;
  logic       i2c_sda_enable;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic [7:0] tx_data_i;
  logic       tx_req_o;
  logic       busy_o;

  modport slave (
    input  i2c_scl_in, i2c_sda_in, tx_data_i,
    output i2c_sda_enable, rx_data_o, rx_valid_o, tx_req_o, busy_o
  );

  modport master (
    output i2c_scl_in, i2c_sda_in, tx_data_i,
    input  i2c_sda_enable, rx_data_o, rx_valid_o, tx_req_o, busy_o
  );
endinterface

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - oversampling I2C target with single 7-bit address
// Bits are sampled on synced SCL rise; SDA is only changed on synced SCL fall.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  i2c_slave_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, RX_DATA, ACK_RX, TX_DATA, ACK_TX, WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       rw_q, rw_d;
  logic       sda_en_q, sda_en_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       load_tx;
  logic       scl_rise, scl_fall, start_det, stop_det, addr_match;

  assign scl_rise   = scl_s2_q & ~scl_prev_q;
  assign scl_fall   = ~scl_s2_q & scl_prev_q;
  assign start_det  = ~sda_s2_q & sda_prev_q & scl_s2_q;
  assign stop_det   = sda_s2_q & ~sda_prev_q & scl_s2_q;
  // Address 0 (general call) never matches, whatever SLAVE_ADDR is.
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (shift_q[7:1] != 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
      shift_q    <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      rw_q       <= 1'b0;
      sda_en_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_s1_q   <= bus.i2c_scl_in;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= bus.i2c_sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      rw_q       <= rw_d;
      sda_en_q   <= sda_en_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    rw_d       = rw_q;
    sda_en_d   = sda_en_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    load_tx    = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      shift_d  = '0;
      cnt_d    = 3'd7;
      full_d   = 1'b0;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      full_d   = 1'b0;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        // full_q marks that all 8 bits are in; the byte is acted on at the next fall.
        ADDR, RX_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            if (cnt_q == 3'd0) full_d = 1'b1;
            else               cnt_d  = cnt_q - 3'd1;
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == RX_DATA) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_en_d   = 1'b1;
              state_d    = ACK_RX;
            end else if (addr_match) begin
              rw_d     = shift_q[0];
              sda_en_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ACK_ADDR;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ACK_ADDR: if (scl_fall) begin
          sda_en_d = 1'b0;
          if (rw_q) begin
            load_tx = 1'b1;
          end else begin
            state_d = RX_DATA;
            cnt_d   = 3'd7;
            full_d  = 1'b0;
          end
        end
        ACK_RX: if (scl_fall) begin
          sda_en_d = 1'b0;
          state_d  = RX_DATA;
          cnt_d    = 3'd7;
          full_d   = 1'b0;
        end
        TX_DATA: if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            sda_en_d = 1'b0;
            full_d   = 1'b0;
            state_d  = ACK_TX;
          end else begin
            cnt_d    = cnt_q - 3'd1;
            shift_d  = {shift_q[6:0], 1'b0};
            sda_en_d = ~shift_q[6];
          end
        end
        // full_q here records a master ACK awaiting the following fall.
        ACK_TX: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              full_d = 1'b1;
            end
          end else if (scl_fall && full_q) begin
            load_tx = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_tx) begin
        shift_d  = bus.tx_data_i;
        sda_en_d = ~bus.tx_data_i[7];
        cnt_d    = 3'd7;
        full_d   = 1'b0;
        state_d  = TX_DATA;
      end
    end
  end

  assign bus.i2c_sda_enable = sda_en_q;
  assign bus.rx_data_o      = rx_data_q;
  assign bus.rx_valid_o     = rx_valid_q;
  assign bus.tx_req_o       = load_tx;
  assign bus.busy_o         = busy_q;
endmodule
